// File: rtl/snake_animator.sv
// Snake animation driver: a train of lit segments circulates around the outer
// perimeter (segments a-f) of a row of seven-segment digits.
module snake_animator #(
  parameter int N_DIGITS   = 2,
  parameter int SNAKE_LEN  = 3,
  parameter int TICK_DIV   = 12500000,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  logic                                enable,
  input  logic                                dir,
  input  logic                                restart,
  output logic [7*N_DIGITS-1:0]               seg,
  output logic [$clog2(2*N_DIGITS+4)-1:0]     pos,
  output logic                                step_pulse,
  output logic                                wrap_pulse
);

  localparam int P     = 2*N_DIGITS + 4;
  localparam int PW    = $clog2(P);
  localparam int SEG_W = 7*N_DIGITS;
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  if (N_DIGITS < 1) begin : g_bad_digits
    $error("snake_animator: N_DIGITS must be >= 1");
  end
  if (TICK_DIV < 1) begin : g_bad_div
    $error("snake_animator: TICK_DIV must be >= 1");
  end
  if ((SNAKE_LEN < 1) || (SNAKE_LEN > P-1)) begin : g_bad_len
    $error("snake_animator: SNAKE_LEN must be within 1..P-1");
  end

  // Bit index within seg of the segment at perimeter position p.
  function automatic int seg_index(input int p);
    int idx;
    if (p < N_DIGITS) begin
      idx = 7*(N_DIGITS-1-p);
    end else if (p == N_DIGITS) begin
      idx = 1;
    end else if (p == N_DIGITS+1) begin
      idx = 2;
    end else if (p <= 2*N_DIGITS+1) begin
      idx = 7*(p-N_DIGITS-2) + 3;
    end else if (p == 2*N_DIGITS+2) begin
      idx = 7*(N_DIGITS-1) + 4;
    end else begin
      idx = 7*(N_DIGITS-1) + 5;
    end
    return idx;
  endfunction

  // Full segment pattern (polarity applied) for a tail position.
  function automatic logic [SEG_W-1:0] decode(input logic [PW-1:0] p);
    logic [SEG_W-1:0] mask;
    logic [SEG_W-1:0] one;
    int               q;
    mask = '0;
    one  = {{(SEG_W-1){1'b0}}, 1'b1};
    for (int i = 0; i < SNAKE_LEN; i++) begin
      q = int'(p) + i;
      if (q >= P) begin
        q = q - P;
      end
      mask = mask | (one << seg_index(q));
    end
    if (ACTIVE_LOW != 0) begin
      mask = ~mask;
    end
    return mask;
  endfunction

  localparam logic [SEG_W-1:0] SEG_RESET = decode({PW{1'b0}});

  logic [CNT_W-1:0] cnt_q,  cnt_d;
  logic [PW-1:0]    pos_q,  pos_d;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;
  logic [SEG_W-1:0] seg_q,  seg_d;

  // Prescaler, position stepping and pulse generation.
  always_comb begin
    cnt_d  = cnt_q;
    pos_d  = pos_q;
    step_d = 1'b0;
    wrap_d = 1'b0;
    if (restart) begin
      cnt_d = '0;
      pos_d = '0;
    end else if (enable) begin
      if (cnt_q == CNT_W'(TICK_DIV-1)) begin
        cnt_d  = '0;
        step_d = 1'b1;
        if (dir) begin
          if (pos_q == {PW{1'b0}}) begin
            pos_d  = PW'(P-1);
            wrap_d = 1'b1;
          end else begin
            pos_d = pos_q - PW'(1);
          end
        end else begin
          if (pos_q == PW'(P-1)) begin
            pos_d  = '0;
            wrap_d = 1'b1;
          end else begin
            pos_d = pos_q + PW'(1);
          end
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
    seg_d = decode(pos_d);
  end

  // State registers; seg is decoded from next pos so it lands with pos.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      pos_q  <= '0;
      step_q <= 1'b0;
      wrap_q <= 1'b0;
      seg_q  <= SEG_RESET;
    end else begin
      cnt_q  <= cnt_d;
      pos_q  <= pos_d;
      step_q <= step_d;
      wrap_q <= wrap_d;
      seg_q  <= seg_d;
    end
  end

  assign seg        = seg_q;
  assign pos        = pos_q;
  assign step_pulse = step_q;
  assign wrap_pulse = wrap_q;

endmodule

// File: tb/tb_snake_animator.sv
// Directed, table-driven bench for snake_animator (N=2, LEN=3, P=8), plus an
// inverted-polarity, divide-by-one instance.
module tb_snake_animator;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        enable, dir, restart;
  logic [13:0] seg;
  logic [2:0]  pos;
  logic        step_pulse, wrap_pulse;
  logic        enable2;
  logic [13:0] seg2;
  logic [2:0]  pos2;
  logic        step2, wrap2;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        en;
    logic        dir;
    logic        rst;
    logic [2:0]  pos;
    logic [13:0] seg;
    logic        step;
    logic        wrap;
  } vec_t;

  vec_t vecs[$];
  int   split_idx;

  logic [13:0] seg_tbl [8] = '{14'h0083, 14'h0007, 14'h000E, 14'h040C,
                               14'h0C08, 14'h1C00, 14'h1880, 14'h1081};

  always #5 clock = ~clock;

  snake_animator #(.N_DIGITS(2), .SNAKE_LEN(3), .TICK_DIV(4), .ACTIVE_LOW(0)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .dir(dir), .restart(restart),
    .seg(seg), .pos(pos), .step_pulse(step_pulse), .wrap_pulse(wrap_pulse)
  );

  snake_animator #(.N_DIGITS(2), .SNAKE_LEN(3), .TICK_DIV(1), .ACTIVE_LOW(1)) dut2 (
    .clock(clock), .reset_n(reset_n), .enable(enable2), .dir(1'b0), .restart(1'b0),
    .seg(seg2), .pos(pos2), .step_pulse(step2), .wrap_pulse(wrap2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic en, input logic d, input logic r,
                              input int p, input logic st, input logic wr);
    vec_t v;
    v.en   = en;
    v.dir  = d;
    v.rst  = r;
    v.pos  = 3'(p);
    v.seg  = seg_tbl[p];
    v.step = st;
    v.wrap = wr;
    return v;
  endfunction

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      enable  = vecs[i].en;
      dir     = vecs[i].dir;
      restart = vecs[i].rst;
      @(posedge clock);
      #1;
      chk($sformatf("v%0d.pos", i),  32'(pos),        32'(vecs[i].pos));
      chk($sformatf("v%0d.seg", i),  32'(seg),        32'(vecs[i].seg));
      chk($sformatf("v%0d.step", i), 32'(step_pulse), 32'(vecs[i].step));
      chk($sformatf("v%0d.wrap", i), 32'(wrap_pulse), 32'(vecs[i].wrap));
    end
  endtask

  initial begin
    logic [13:0] inv;

    // Forward lap: a step every 4th enabled cycle, wrap on 7->0.
    for (int c = 1; c <= 32; c++) begin
      vecs.push_back(mk(1'b1, 1'b0, 1'b0, (c/4)%8, (c%4) == 0, c == 32));
    end
    // Reverse from 0: wrap to 7, then 6; dir toggles mid-prescale.
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 7, 1'b1, 1'b1));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 7, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 7, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 7, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 6, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 6, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 6, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 6, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 5, 1'b1, 1'b0));
    // Bring cnt to 3 at pos 5, freeze with enable=0, then restart.
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 5, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 5, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 5, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 5, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 5, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b0));
    for (int c = 1; c <= 10; c++) begin
      vecs.push_back(mk(1'b1, 1'b0, 1'b0, c/4, (c%4) == 0, 1'b0));
    end
    split_idx = vecs.size();
    // After async reset mid-prescale: a full 4 cycles to the first step.
    for (int c = 1; c <= 4; c++) begin
      vecs.push_back(mk(1'b1, 1'b0, 1'b0, c/4, (c%4) == 0, 1'b0));
    end

    reset_n = 1'b0;
    enable  = 1'b0;
    dir     = 1'b0;
    restart = 1'b0;
    enable2 = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst.pos",  32'(pos),        32'd0);
    chk("rst.seg",  32'(seg),        32'h0083);
    chk("rst.step", 32'(step_pulse), 32'd0);
    chk("rst.wrap", 32'(wrap_pulse), 32'd0);
    chk("rst.seg2", 32'(seg2),       32'h3F7C);
    reset_n = 1'b1;

    for (int c = 0; c < 20; c++) begin
      @(posedge clock);
      #1;
      chk($sformatf("idle%0d.pos", c),  32'(pos),        32'd0);
      chk($sformatf("idle%0d.seg", c),  32'(seg),        32'h0083);
      chk($sformatf("idle%0d.step", c), 32'(step_pulse), 32'd0);
      chk($sformatf("idle%0d.wrap", c), 32'(wrap_pulse), 32'd0);
    end

    run_vecs(0, split_idx);

    // Asynchronous reset between clock edges at pos 2, cnt 2.
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst.pos",  32'(pos),        32'd0);
    chk("arst.seg",  32'(seg),        32'h0083);
    chk("arst.step", 32'(step_pulse), 32'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    run_vecs(split_idx, vecs.size());

    // Inverted polarity with a step on every enabled cycle.
    enable = 1'b0;
    @(posedge clock);
    #1;
    chk("al.pos0", 32'(pos2),  32'd0);
    chk("al.seg0", 32'(seg2),  32'h3F7C);
    chk("al.idle", 32'(step2), 32'd0);
    enable2 = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(posedge clock);
      #1;
      inv = ~seg_tbl[c%8];
      chk($sformatf("al%0d.pos", c),  32'(pos2),  32'(c%8));
      chk($sformatf("al%0d.seg", c),  32'(seg2),  32'(inv));
      chk($sformatf("al%0d.step", c), 32'(step2), 32'd1);
      chk($sformatf("al%0d.wrap", c), 32'(wrap2), (c == 8) ? 32'd1 : 32'd0);
    end
    enable2 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
